// File: rtl/motoro3_gate_monitor.sv
// Gate-drive read-back monitor: filters PWM, recovers sector/direction/period.
// Define MOTORO3_MON_DEADTIME_CHK_EN to build the per-phase dead-time checker.
module motoro3_gate_monitor #(
  parameter int FILT_LEN = 16,
  parameter int PERIOD_W = 25,
  parameter int DEAD_CYC = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                aHp,
  input  logic                aLp,
  input  logic                bHp,
  input  logic                bLp,
  input  logic                cHp,
  input  logic                cLp,
  input  logic                monClr,
  output logic [2:0]          sector,
  output logic                sectorVld,
  output logic                stepPulse,
  output logic                dirRev,
  output logic [PERIOD_W-1:0] period,
  output logic                periodVld,
  output logic                shootFault,
  output logic                deadFault,
  output logic [7:0]          errCnt
);

  localparam logic [7:0] FL = 8'(FILT_LEN);

  logic [2:0] hp_q, hp_d, lp_q, lp_d;
  logic [2:0] cand_q, cand_d, p_q, p_d;
  logic [2:0][7:0] cnt_q, cnt_d;
  logic [2:0] sec_n, sec_q, sec_d, dlt;
  logic vld_q, vld_d, new_vld;
  logic chg, fwd, rev, bad, entry0;
  logic step_q, step_d, dir_q, dir_d;
  logic [PERIOD_W-1:0] pcnt_q, pcnt_d, per_q, per_d;
  logic armed_q, armed_d, pvld_q, pvld_d;
  logic shoot_q, shoot_d;
  logic [7:0] err_q, err_d;

  // Phase index 2/1/0 = a/b/c so p_q reads directly as {pa,pb,pc}.
  always_comb begin
    hp_d   = {aHp, bHp, cHp};
    lp_d   = {aLp, bLp, cLp};
    cand_d = cand_q;
    cnt_d  = cnt_q;
    p_d    = p_q;
    for (int i = 0; i < 3; i++) begin
      if (hp_q[i] ^ lp_q[i]) begin
        if (hp_q[i] == cand_q[i]) begin
          cnt_d[i] = (cnt_q[i] >= FL) ? FL : cnt_q[i] + 8'd1;
        end else begin
          cand_d[i] = hp_q[i];
          cnt_d[i]  = 8'd1;
        end
      end else begin
        cnt_d[i] = 8'd0;
      end
      if (cnt_d[i] == FL) p_d[i] = cand_d[i];
    end
  end

  always_comb begin
    case (p_q)
      3'b100:  sec_n = 3'd0;
      3'b110:  sec_n = 3'd1;
      3'b010:  sec_n = 3'd2;
      3'b011:  sec_n = 3'd3;
      3'b001:  sec_n = 3'd4;
      3'b101:  sec_n = 3'd5;
      default: sec_n = 3'd7;
    endcase
  end

  // Distance is taken mod 6; wrap in 3-bit arithmetic still lands on 1..5.
  always_comb begin
    new_vld = (sec_n != 3'd7);
    chg     = new_vld && vld_q && (sec_n != sec_q);
    dlt     = (sec_n >= sec_q) ? sec_n - sec_q : sec_n + 3'd6 - sec_q;
    fwd     = chg && (dlt == 3'd1);
    rev     = chg && (dlt == 3'd5);
    bad     = chg && !fwd && !rev;
    entry0  = (fwd || rev) && (sec_n == 3'd0);

    sec_d  = sec_n;
    vld_d  = new_vld;
    step_d = fwd || rev;
    dir_d  = fwd ? 1'b0 : (rev ? 1'b1 : dir_q);

    pcnt_d = entry0 ? PERIOD_W'(1)
           : (&pcnt_q ? pcnt_q : pcnt_q + PERIOD_W'(1));
    per_d  = entry0 ? pcnt_q : per_q;

    armed_d = armed_q;
    pvld_d  = pvld_q;
    if (entry0) begin
      armed_d = 1'b1;
      if (armed_q) pvld_d = 1'b1;
    end
    if (monClr || !new_vld) begin
      armed_d = 1'b0;
      pvld_d  = 1'b0;
    end

    shoot_d = (|(hp_q & lp_q)) | (shoot_q & ~monClr);

    if (bad) begin
      err_d = monClr ? 8'd1 : ((err_q == 8'hFF) ? err_q : err_q + 8'd1);
    end else begin
      err_d = monClr ? 8'd0 : err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hp_q    <= '0;
      lp_q    <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      sec_q   <= 3'd7;
      vld_q   <= 1'b0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      pcnt_q  <= '0;
      per_q   <= '0;
      armed_q <= 1'b0;
      pvld_q  <= 1'b0;
      shoot_q <= 1'b0;
      err_q   <= '0;
    end else begin
      hp_q    <= hp_d;
      lp_q    <= lp_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      sec_q   <= sec_d;
      vld_q   <= vld_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      pcnt_q  <= pcnt_d;
      per_q   <= per_d;
      armed_q <= armed_d;
      pvld_q  <= pvld_d;
      shoot_q <= shoot_d;
      err_q   <= err_d;
    end
  end

  assign sector     = sec_q;
  assign sectorVld  = vld_q;
  assign stepPulse  = step_q;
  assign dirRev     = dir_q;
  assign period     = per_q;
  assign periodVld  = pvld_q;
  assign shootFault = shoot_q;
  assign errCnt     = err_q;

`ifdef MOTORO3_MON_DEADTIME_CHK_EN
  localparam logic [7:0] DC = 8'(DEAD_CYC);

  logic [2:0] hpp_q, lpp_q, side_q, side_d;
  logic [2:0][7:0] dc_q, dc_d;
  logic dead_q, dead_d, viol;

  // side_q = 1 when the window was opened by Hp falling, so Lp is watched.
  always_comb begin
    side_d = side_q;
    dc_d   = dc_q;
    viol   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (dc_q[i] != 8'd0) begin
        if (side_q[i] && !lpp_q[i] && lp_q[i]) viol = 1'b1;
        if (!side_q[i] && !hpp_q[i] && hp_q[i]) viol = 1'b1;
      end
      if ((hpp_q[i] & ~hp_q[i]) | (lpp_q[i] & ~lp_q[i])) begin
        dc_d[i]   = DC;
        side_d[i] = hpp_q[i] & ~hp_q[i];
      end else if (dc_q[i] != 8'd0) begin
        dc_d[i] = dc_q[i] - 8'd1;
      end
    end
    dead_d = viol | (dead_q & ~monClr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hpp_q  <= '0;
      lpp_q  <= '0;
      side_q <= '0;
      dc_q   <= '0;
      dead_q <= 1'b0;
    end else begin
      hpp_q  <= hp_q;
      lpp_q  <= lp_q;
      side_q <= side_d;
      dc_q   <= dc_d;
      dead_q <= dead_d;
    end
  end

  assign deadFault = dead_q;
`else
  assign deadFault = (DEAD_CYC < 0);
`endif

endmodule

// File: tb/tb_motoro3_gate_monitor.sv
// Bench for motoro3_gate_monitor: directed table, corner sequences, random
// sector walks against a transaction-level model.
module tb_motoro3_gate_monitor;

  localparam int FL = 16;
`ifdef MOTORO3_MON_DEADTIME_CHK_EN
  localparam int EXP_DEAD = 1;
`else
  localparam int EXP_DEAD = 0;
`endif

  logic clk = 1'b0;
  logic rst, monClr;
  logic aHp, aLp, bHp, bLp, cHp, cLp;
  logic [2:0] sector;
  logic sectorVld, stepPulse, dirRev, periodVld;
  logic shootFault, deadFault;
  logic [24:0] period;
  logic [7:0] errCnt;

  motoro3_gate_monitor dut (
    .clk(clk), .rst(rst),
    .aHp(aHp), .aLp(aLp), .bHp(bHp), .bLp(bLp), .cHp(cHp), .cLp(cLp),
    .monClr(monClr),
    .sector(sector), .sectorVld(sectorVld), .stepPulse(stepPulse),
    .dirRev(dirRev), .period(period), .periodVld(periodVld),
    .shootFault(shootFault), .deadFault(deadFault), .errCnt(errCnt)
  );

  always #50 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, obs_steps = 0;
  int m_sec = -1, m_dir = 0, m_err = 0, m_steps = 0;
  int m_armed = 0, m_pvld = 0, m_period = 0, m_last0 = 0;
  int lat;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (stepPulse === 1'b1) obs_steps <= obs_steps + 1;

  typedef struct {
    int code; int sec; int dir; int err; int steps; int pvld; int per;
  } vec_t;
  vec_t tbl[19];

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // Polarity pattern {pa,pb,pc} for each commutation sector; 6/7 are invalid.
  function automatic logic [2:0] pol(input int code);
    case (code)
      0: return 3'b100;
      1: return 3'b110;
      2: return 3'b010;
      3: return 3'b011;
      4: return 3'b001;
      5: return 3'b101;
      6: return 3'b000;
      default: return 3'b111;
    endcase
  endfunction

  task automatic drive(input int code);
    logic [2:0] p;
    p = pol(code);
    {aHp, bHp, cHp} = p;
    {aLp, bLp, cLp} = ~p;
  endtask

  task automatic model(input int code);
    int s, d;
    s = (code < 6) ? code : -1;
    if (s < 0) begin
      m_armed = 0;
      m_pvld  = 0;
    end else if (m_sec >= 0 && s != m_sec) begin
      d = (s - m_sec + 6) % 6;
      if (d == 1 || d == 5) begin
        m_steps++;
        m_dir = (d == 5);
        if (s == 0) begin
          if (m_armed != 0) begin
            m_pvld   = 1;
            m_period = cyc - m_last0;
          end
          m_armed = 1;
          m_last0 = cyc;
        end
      end else if (m_err < 255) begin
        m_err++;
      end
    end
    m_sec = s;
  endtask

  task automatic model_clr();
    m_err = 0; m_armed = 0; m_pvld = 0;
  endtask

  task automatic seg(input int code, input int n);
    int tgt;
    tgt = (code < 6) ? code : 7;
    drive(code);
    model(code);
    lat = -1;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (lat < 0 && int'(sector) == tgt) lat = i;
    end
    @(negedge clk);
  endtask

  task automatic chk_state(input string t);
    chk({t, ".sector"}, int'(sector), (m_sec < 0) ? 7 : m_sec);
    chk({t, ".vld"}, int'(sectorVld), (m_sec >= 0) ? 1 : 0);
    chk({t, ".dir"}, int'(dirRev), m_dir);
    chk({t, ".err"}, int'(errCnt), m_err);
    chk({t, ".steps"}, obs_steps, m_steps);
    chk({t, ".pvld"}, int'(periodVld), m_pvld);
    if (m_pvld != 0) chk({t, ".period"}, int'(period), m_period);
  endtask

  task automatic chk_reset(input string t);
    chk({t, ".sector"}, int'(sector), 7);
    chk({t, ".vld"}, int'(sectorVld), 0);
    chk({t, ".step"}, int'(stepPulse), 0);
    chk({t, ".dir"}, int'(dirRev), 0);
    chk({t, ".period"}, int'(period), 0);
    chk({t, ".pvld"}, int'(periodVld), 0);
    chk({t, ".shoot"}, int'(shootFault), 0);
    chk({t, ".dead"}, int'(deadFault), 0);
    chk({t, ".err"}, int'(errCnt), 0);
  endtask

  initial begin
    int prev, nchg, k0;
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 1, 0, 0};
    tbl[2]  = '{2, 2, 0, 0, 2, 0, 0};
    tbl[3]  = '{3, 3, 0, 0, 3, 0, 0};
    tbl[4]  = '{4, 4, 0, 0, 4, 0, 0};
    tbl[5]  = '{5, 5, 0, 0, 5, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 6, 0, 0};
    tbl[7]  = '{1, 1, 0, 0, 7, 0, 0};
    tbl[8]  = '{2, 2, 0, 0, 8, 0, 0};
    tbl[9]  = '{3, 3, 0, 0, 9, 0, 0};
    tbl[10] = '{4, 4, 0, 0, 10, 0, 0};
    tbl[11] = '{5, 5, 0, 0, 11, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 12, 1, 6000};
    tbl[13] = '{5, 5, 1, 0, 13, 1, 6000};
    tbl[14] = '{4, 4, 1, 0, 14, 1, 6000};
    tbl[15] = '{5, 5, 0, 0, 15, 1, 6000};
    tbl[16] = '{0, 0, 0, 0, 16, 1, 4000};
    tbl[17] = '{2, 2, 0, 1, 16, 1, 4000};
    tbl[18] = '{0, 0, 0, 2, 16, 1, 4000};

    rst = 1'b1; monClr = 1'b0;
    {aHp, aLp, bHp, bLp, cHp, cLp} = '0;
    repeat (3) @(negedge clk);
    chk_reset("rst0");
    rst = 1'b0;
    @(negedge clk);

    prev = 7;
    foreach (tbl[i]) begin
      seg(tbl[i].code, 1000);
      chk($sformatf("t%0d.sector", i), int'(sector), tbl[i].sec);
      chk($sformatf("t%0d.vld", i), int'(sectorVld), 1);
      chk($sformatf("t%0d.dir", i), int'(dirRev), tbl[i].dir);
      chk($sformatf("t%0d.err", i), int'(errCnt), tbl[i].err);
      chk($sformatf("t%0d.steps", i), obs_steps, tbl[i].steps);
      chk($sformatf("t%0d.pvld", i), int'(periodVld), tbl[i].pvld);
      if (tbl[i].pvld != 0)
        chk($sformatf("t%0d.period", i), int'(period), tbl[i].per);
      if (tbl[i].sec != prev)
        chk($sformatf("t%0d.latency", i), lat, FL + 2);
      prev = tbl[i].sec;
    end

    // PWM chopping on phase A inside sector 0
    nchg = 0;
    k0 = obs_steps;
    for (int k = 0; k < 24; k++) begin
      aHp = k[0];
      aLp = ~k[0];
      repeat (8) begin
        @(negedge clk);
        if (sector !== 3'd0) nchg++;
      end
    end
    repeat (40) begin
      @(negedge clk);
      if (sector !== 3'd0) nchg++;
    end
    chk("chop.sector_moves", nchg, 0);
    chk("chop.steps", obs_steps - k0, 0);

    // One-cycle shoot-through on phase A
    aLp = 1'b1;
    @(negedge clk);
    aLp = 1'b0;
    chk("shoot.before", int'(shootFault), 0);
    @(posedge clk); #1;
    chk("shoot.set", int'(shootFault), 1);
    repeat (10) @(negedge clk);
    chk("shoot.held", int'(shootFault), 1);
    monClr = 1'b1;
    @(negedge clk);
    monClr = 1'b0;
    model_clr();
    chk("shoot.clr", int'(shootFault), 0);
    chk("clr.err", int'(errCnt), 0);
    chk("clr.pvld", int'(periodVld), 0);
    aLp = 1'b1;
    @(negedge clk);
    aLp = 1'b0;
    monClr = 1'b1;
    @(negedge clk);
    monClr = 1'b0;
    model_clr();
    chk("shoot.clr_vs_set", int'(shootFault), 1);

    // Dead-time: A goes H -> Z -> L after 5 cycles (sector 5 -> 4)
    seg(5, 100);
    chk_state("dt.pre");
    aHp = 1'b0;
    repeat (5) @(negedge clk);
    seg(4, 100);
    chk("dt.short", int'(deadFault), EXP_DEAD);
    chk_state("dt.s4");
    monClr = 1'b1;
    @(negedge clk);
    monClr = 1'b0;
    model_clr();
    chk("dt.clr", int'(deadFault), 0);
    aLp = 1'b0;
    repeat (12) @(negedge clk);
    seg(5, 100);
    chk("dt.long", int'(deadFault), 0);
    chk_state("dt.s5");

    // Random sector walks, including invalid codes and skips
    for (int r = 0; r < 60; r++) begin
      seg(int'($urandom_range(0, 7)), int'($urandom_range(24, 150)));
      chk_state($sformatf("rnd%0d", r));
    end

    // Asynchronous reset mid-rotation
    seg(1, 40);
    drive(2);
    repeat (10) @(negedge clk);
    #10 rst = 1'b1;
    #1;
    chk_reset("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    m_sec = -1; m_dir = 0;
    model_clr();
    seg(2, 60);
    chk_state("post_rst");

    // errCnt saturation through repeated 0 <-> 2 skips
    for (int k = 0; k < 256; k++) seg((k % 2 == 0) ? 0 : 2, 24);
    chk("sat.err", int'(errCnt), 255);
    chk_state("sat");
    seg(0, 24);
    chk("sat.more", int'(errCnt), 255);
    chk("sat.steps", obs_steps, m_steps);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
